// File: rtl/seven_seg_ctrl_pkg.sv
// Shared definitions for the 4-digit 7-segment controller: control-word layout,
// scan states, the segment table and the leading-zero-blanking helper.
package seven_seg_ctrl_pkg;

    // Word address the peripheral decode compares against to raise wr_en.
    localparam logic [31:0] HEX_ADDR = 32'hFFFF_0010;

    localparam int          CTRL_W  = 25;
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Packed so that bit 0 of the struct is bit 0 of the stored word.
    typedef struct packed {
        logic        lzb;
        logic [3:0]  mask;
        logic [3:0]  dot;
        logic [15:0] value;
    } ctrl_word_t;

    // Active-low {g,f,e,d,c,b,a}; letters b and d are lower case on the board.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // A digit is a leading zero when it and every more significant nibble are 0;
    // the rightmost digit always shows so a value of zero still reads "0".
    function automatic logic lzbBlanks(input logic [15:0] value, input logic [1:0] k);
        logic [15:0] upper;
        upper = value >> {k, 2'b00};
        return (k != 2'd0) && (upper == 16'd0);
    endfunction

endpackage

// File: rtl/seven_seg_ctrl_if.sv
// Store/readback port of the HEX register as seen from the data-memory decode.
interface seven_seg_ctrl_if;

    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output wr_en,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output rd_data
    );

endinterface

// File: rtl/seven_seg_ctrl_hex_to_seg.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg
    import seven_seg_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_ctrl.sv
// Memory-mapped 4-digit 7-segment controller: a written control word is latched into
// a shadow copy once per frame and scanned digit by digit with a dark guard slot between.
module seven_seg_ctrl
    import seven_seg_ctrl_pkg::*;
#(
    parameter int DRIVE_CYCLES = 100000,
    parameter int GUARD_CYCLES = 16
)
(
    input  logic                   clk,
    input  logic                   rst,
    seven_seg_ctrl_if.slave        bus,
    output logic [6:0]             hex,
    output logic                   hex_dot,
    output logic [3:0]             hex_sel
);

    localparam int CNT_MAX = (DRIVE_CYCLES > GUARD_CYCLES) ? DRIVE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    ctrl_word_t       ctrl_q, ctrl_d;
    ctrl_word_t       shadow_q;
    scan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       digit_q;
    logic [6:0]       hexOut_q;
    logic             dotOut_q;
    logic [3:0]       selOut_q;

    logic [3:0]       curNibble;
    logic [6:0]       digitSeg;
    logic [6:0]       slotHex;
    logic             slotDot;
    logic [3:0]       slotSel;
    logic             unusedWrHigh;

    // Bits 31:25 of the store have no home in the register and always read back as 0.
    assign unusedWrHigh = ^bus.wr_data[31:CTRL_W];

    always_comb begin
        ctrl_d = ctrl_q;
        if (bus.wr_en) begin
            ctrl_d = bus.wr_data[CTRL_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.rd_data = {7'b0, ctrl_q};

    assign curNibble = shadow_q.value[{digit_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (curNibble),
        .seg_o    (digitSeg)
    );

    // Pattern for the digit about to be driven; only ever sampled on GUARD -> DRIVE.
    always_comb begin
        slotHex = SEG_OFF;
        slotDot = 1'b1;
        slotSel = 4'hF;
        if (shadow_q.mask[digit_q]) begin
            slotSel = ~(4'b0001 << digit_q);
            slotDot = ~shadow_q.dot[digit_q];
            slotHex = (shadow_q.lzb && lzbBlanks(shadow_q.value, digit_q)) ? SEG_OFF : digitSeg;
        end
    end

    // The counter resets to the guard reload so the first guard slot is full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GUARD;
            cnt_q    <= GUARD_LOAD;
            digit_q  <= 2'd0;
            shadow_q <= '0;
            hexOut_q <= SEG_OFF;
            dotOut_q <= 1'b1;
            selOut_q <= 4'hF;
        end else begin
            case (state_q)
                GUARD: begin
                    if (cnt_q == '0) begin
                        state_q  <= DRIVE;
                        cnt_q    <= DRIVE_LOAD;
                        hexOut_q <= slotHex;
                        dotOut_q <= slotDot;
                        selOut_q <= slotSel;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_q  <= GUARD;
                        cnt_q    <= GUARD_LOAD;
                        digit_q  <= digit_q + 2'd1;
                        hexOut_q <= SEG_OFF;
                        dotOut_q <= 1'b1;
                        selOut_q <= 4'hF;
                        // Frame boundary: a store on this same edge waits for the next one.
                        if (digit_q == 2'd3) begin
                            shadow_q <= ctrl_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign hex     = hexOut_q;
    assign hex_dot = dotOut_q;
    assign hex_sel = selOut_q;

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Scoreboard bench for seven_seg_ctrl: stimulus pushes per-cycle expectations built from
// hand-decoded digit vectors, a negedge monitor pops and compares them against the pins.
`timescale 1ns/1ps
module tb_seven_seg_ctrl;

    localparam int DRIVE = 4;
    localparam int GUARD = 1;
    localparam int SLOT  = DRIVE + GUARD;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] hex;
    logic       hexDot;
    logic [3:0] hexSel;

    seven_seg_ctrl_if bus ();

    seven_seg_ctrl #(
        .DRIVE_CYCLES (DRIVE),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .hex     (hex),
        .hex_dot (hexDot),
        .hex_sel (hexSel)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic [31:0]      word;
        logic [31:0]      rd;
        logic [3:0][6:0]  hex;
        logic [3:0]       dot;
        logic [3:0][3:0]  sel;
    } vec_t;

    typedef struct {
        logic [6:0]  hex;
        logic        dot;
        logic [3:0]  sel;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t dispVec, ctrlVec;
    vec_t vZero, v2, v3, v4, v5, v6;

    function automatic vec_t mkVec(input logic [31:0] word, input logic [31:0] rd,
                                   input logic [27:0] hexs, input logic [3:0] dots,
                                   input logic [15:0] sels);
        vec_t v;
        v.word = word;
        v.rd   = rd;
        v.hex  = hexs;
        v.dot  = dots;
        v.sel  = sels;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp, input int atCyc);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, atCyc, act, exp);
        end
    endtask

    // Expected pins for the current cycle of the scan, given what the shadow holds.
    task automatic pushExpect();
        exp_t e;
        int   phase;
        int   slot;
        phase = cyc % FRAME;
        slot  = phase / SLOT;
        e.cyc = cyc;
        e.rd  = ctrlVec.rd;
        if ((phase % SLOT) < GUARD) begin
            e.hex = 7'h7F;
            e.dot = 1'b1;
            e.sel = 4'hF;
        end else begin
            e.hex = dispVec.hex[slot];
            e.dot = dispVec.dot[slot];
            e.sel = dispVec.sel[slot];
        end
        expQ.push_back(e);
    endtask

    task automatic pushDark();
        exp_t e;
        e.cyc = -1;
        e.rd  = 32'h0;
        e.hex = 7'h7F;
        e.dot = 1'b1;
        e.sel = 4'hF;
        expQ.push_back(e);
    endtask

    // One clock of scanning, optionally storing a new word on the coming edge.
    task automatic applyStimulus(input bit doWrite, input vec_t v);
        pushExpect();
        bus.wr_en   = doWrite;
        bus.wr_data = doWrite ? v.word : 32'h0;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;
        if (((cyc + 1) % FRAME) == 0) dispVec = ctrlVec;
        if (doWrite) ctrlVec = v;
        cyc++;
    endtask

    task automatic runTo(input int endCyc);
        while (cyc < endCyc) applyStimulus(1'b0, vZero);
    endtask

    task automatic holdReset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            pushDark();
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        cyc     = 0;
        dispVec = vZero;
        ctrlVec = vZero;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("hex",     32'(hex),    32'(e.hex), e.cyc);
                checkOutput("hex_dot", 32'(hexDot), 32'(e.dot), e.cyc);
                checkOutput("hex_sel", 32'(hexSel), 32'(e.sel), e.cyc);
                checkOutput("rd_data", bus.rd_data, e.rd,       e.cyc);
            end
        end
    end

    initial begin : stimulus
        vZero = mkVec(32'h0, 32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111,
                      {4'hF, 4'hF, 4'hF, 4'hF});
        v2 = mkVec(32'h00F1_1A8F, 32'h00F1_1A8F, {7'h79, 7'h08, 7'h00, 7'h0E}, 4'b1110,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        v3 = mkVec(32'h01F2_0008, 32'h01F2_0008, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b1101,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        v4 = mkVec(32'h0050_FFFF, 32'h0050_FFFF, {7'h7F, 7'h0E, 7'h7F, 7'h0E}, 4'b1111,
                   {4'hF, 4'b1011, 4'hF, 4'b1110});
        v5 = mkVec(32'h00F0_4321, 32'h00F0_4321, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        v6 = mkVec(32'hFEF0_DCBA, 32'h00F0_DCBA, {7'h21, 7'h46, 7'h03, 7'h08}, 4'b1111,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        dispVec     = vZero;
        ctrlVec     = vZero;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;

        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] power-on reset, then an all-dark frame");
        holdReset(3);
        runTo(3);
        applyStimulus(1'b1, v2);
        $display("[TB] LZB word, masked word, mid-slot store");
        runTo(25);
        applyStimulus(1'b1, v3);
        runTo(45);
        applyStimulus(1'b1, v4);
        runTo(67);
        applyStimulus(1'b1, v5);
        $display("[TB] store on the frame-wrap edge, high bits dropped");
        runTo(99);
        applyStimulus(1'b1, v6);
        runTo(142);

        $display("[TB] reset during digit0 drive, then restart from guard digit0");
        rst = 1'b1;
        pushDark();
        @(posedge clk);
        #1;
        holdReset(2);
        runTo(2);
        applyStimulus(1'b1, v2);
        runTo(2 * FRAME);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
